// File: rtl/spi_master_xfer.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_xfer
// Brief    : Full-duplex SPI master frame engine with runtime CPOL/CPHA.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_xfer #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 2,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                  CLK,
    input  logic                  CLR,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic [DATA_WIDTH-1:0] RX_DATA,
    output logic                  RX_VALID,
    input  logic                  CPOL,
    input  logic                  CPHA,
    output logic                  BUSY,
    output logic                  SCLK,
    output logic                  MOSI,
    input  logic                  MISO,
    output logic                  CS_N
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_CNT_W = $clog2(2 * DATA_WIDTH + 1);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(2 * DATA_WIDTH);
    localparam logic [c_CNT_W-1:0] c_HALF_FIN  = c_CNT_W'(2 * DATA_WIDTH - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SETUP = 2'd1;
    localparam logic [1:0] c_SHIFT = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    logic [1:0]            r_state;
    logic [c_DIV_W-1:0]    r_div_cnt;
    logic [c_CNT_W-1:0]    r_half_cnt;
    logic [DATA_WIDTH-1:0] r_shift_tx;
    logic [DATA_WIDTH-1:0] r_shift_rx;
    logic [DATA_WIDTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_cpol;
    logic                  r_cpha;
    logic                  r_sclk;
    logic                  r_mosi;

    logic w_idle;
    logic w_div_end;
    logic w_lead;
    logic w_sample;
    logic w_advance;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] d);
        return LSB_FIRST ? d[0] : d[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] d);
        return LSB_FIRST ? {1'b0, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], 1'b0};
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] d,
                                                       input logic b);
        return LSB_FIRST ? {b, d[DATA_WIDTH-1:1]} : {d[DATA_WIDTH-2:0], b};
    endfunction

    // r_half_cnt counts SCLK toggles already issued, so it is also the index
    // of the toggle about to happen: even indices are leading edges.
    always_comb begin
        w_idle    = (r_state == c_IDLE);
        w_div_end = (r_div_cnt == c_DIV_LAST);
        w_lead    = ~r_half_cnt[0];
        w_sample  = w_lead ^ r_cpha;
        w_advance = r_cpha ? w_lead : (~w_lead && (r_half_cnt != c_HALF_FIN));
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state    <= c_IDLE;
            r_div_cnt  <= '0;
            r_half_cnt <= '0;
            r_shift_tx <= '0;
            r_shift_rx <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_sclk     <= CPOL;
                    r_mosi     <= 1'b0;
                    r_div_cnt  <= '0;
                    r_half_cnt <= '0;
                    if (TX_VALID) begin
                        r_cpol  <= CPOL;
                        r_cpha  <= CPHA;
                        r_state <= c_SETUP;
                        if (!CPHA) begin
                            r_mosi     <= first_bit(TX_DATA);
                            r_shift_tx <= shift_out(TX_DATA);
                        end else begin
                            r_shift_tx <= TX_DATA;
                        end
                    end
                end
                c_SETUP, c_SHIFT: begin
                    r_div_cnt <= w_div_end ? '0 : r_div_cnt + 1'b1;
                    if (w_div_end) begin
                        if ((r_state == c_SHIFT) && (r_half_cnt == c_HALF_LAST)) begin
                            r_state <= c_HOLD;
                        end else begin
                            r_state    <= c_SHIFT;
                            r_sclk     <= ~r_sclk;
                            r_half_cnt <= r_half_cnt + 1'b1;
                            if (w_sample) begin
                                r_shift_rx <= shift_in(r_shift_rx, MISO);
                            end
                            if (w_advance) begin
                                r_mosi     <= first_bit(r_shift_tx);
                                r_shift_tx <= shift_out(r_shift_tx);
                            end
                        end
                    end
                end
                c_HOLD: begin
                    r_div_cnt <= w_div_end ? '0 : r_div_cnt + 1'b1;
                    if (w_div_end) begin
                        r_state    <= c_IDLE;
                        r_rx_data  <= r_shift_rx;
                        r_rx_valid <= 1'b1;
                        r_mosi     <= 1'b0;
                        r_sclk     <= r_cpol;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign TX_READY = w_idle;
    assign BUSY     = ~w_idle;
    assign CS_N     = w_idle;
    assign SCLK     = r_sclk;
    assign MOSI     = r_mosi;
    assign RX_DATA  = r_rx_data;
    assign RX_VALID = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_xfer
// Brief    : Self-checking bench for spi_master_xfer, LSB- and MSB-first units.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_xfer;

    localparam int c_W    = 8;
    localparam int c_DIV  = 2;
    localparam int c_LEN  = c_DIV * (2 * c_W + 2);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [c_W-1:0] tx_data = '0;
    logic tx_valid = 1'b0;
    logic cpol = 1'b0;
    logic cpha = 1'b0;
    logic sel = 1'b0;
    logic loop = 1'b1;
    logic miso_drv = 1'b0;

    logic w_tx_valid_l, w_tx_valid_m;
    logic w_ready_l, w_ready_m, w_rxv_l, w_rxv_m, w_busy_l, w_busy_m;
    logic w_sclk_l, w_sclk_m, w_mosi_l, w_mosi_m, w_csn_l, w_csn_m;
    logic w_miso_l, w_miso_m;
    logic [c_W-1:0] w_rx_l, w_rx_m;
    logic w_ready, w_rxv, w_busy, w_sclk, w_mosi, w_csn;
    logic [c_W-1:0] w_rx;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign w_tx_valid_l = tx_valid & ~sel;
    assign w_tx_valid_m = tx_valid & sel;
    assign w_miso_l = loop ? w_mosi_l : miso_drv;
    assign w_miso_m = loop ? w_mosi_m : miso_drv;

    assign w_ready = sel ? w_ready_m : w_ready_l;
    assign w_rxv   = sel ? w_rxv_m   : w_rxv_l;
    assign w_busy  = sel ? w_busy_m  : w_busy_l;
    assign w_sclk  = sel ? w_sclk_m  : w_sclk_l;
    assign w_mosi  = sel ? w_mosi_m  : w_mosi_l;
    assign w_csn   = sel ? w_csn_m   : w_csn_l;
    assign w_rx    = sel ? w_rx_m    : w_rx_l;

    spi_master_xfer #(.DATA_WIDTH(c_W), .CLK_DIV(c_DIV), .LSB_FIRST(1'b1)) dut_lsb (
        .CLK(clk), .CLR(rst), .TX_DATA(tx_data), .TX_VALID(w_tx_valid_l),
        .TX_READY(w_ready_l), .RX_DATA(w_rx_l), .RX_VALID(w_rxv_l),
        .CPOL(cpol), .CPHA(cpha), .BUSY(w_busy_l), .SCLK(w_sclk_l),
        .MOSI(w_mosi_l), .MISO(w_miso_l), .CS_N(w_csn_l)
    );

    spi_master_xfer #(.DATA_WIDTH(c_W), .CLK_DIV(c_DIV), .LSB_FIRST(1'b0)) dut_msb (
        .CLK(clk), .CLR(rst), .TX_DATA(tx_data), .TX_VALID(w_tx_valid_m),
        .TX_READY(w_ready_m), .RX_DATA(w_rx_m), .RX_VALID(w_rxv_m),
        .CPOL(cpol), .CPHA(cpha), .BUSY(w_busy_m), .SCLK(w_sclk_m),
        .MOSI(w_mosi_m), .MISO(w_miso_m), .CS_N(w_csn_m)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit i of the serial stream for a word in the given order.
    function automatic logic order_bit(input logic [c_W-1:0] w, input int i, input logic msb);
        return msb ? w[c_W-1-i] : w[i];
    endfunction

    task automatic chk_idle(input string tag, input logic [c_W-1:0] rx_exp, input logic sclk_exp);
        chk({tag, "_csn"},   32'(w_csn),   32'd1);
        chk({tag, "_busy"},  32'(w_busy),  32'd0);
        chk({tag, "_ready"}, 32'(w_ready), 32'd1);
        chk({tag, "_mosi"},  32'(w_mosi),  32'd0);
        chk({tag, "_sclk"},  32'(w_sclk),  32'(sclk_exp));
        chk({tag, "_rx"},    32'(w_rx),    32'(rx_exp));
    endtask

    task automatic run_frame(input string tag, input logic msb, input logic [c_W-1:0] tx,
                             input logic pol, input logic pha, input logic lb,
                             input logic [c_W-1:0] mword);
        int cycles, toggles, leads, nsamp;
        logic prev_sclk, prev_mosi, is_lead, timing_ok, seq_ok, done;
        sel = msb;
        loop = lb;
        miso_drv = order_bit(mword, 0, msb);
        @(negedge clk);
        tx_data = tx; cpol = pol; cpha = pha; tx_valid = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_acc_csn"},  32'(w_csn),  32'd0);
        chk({tag, "_acc_busy"}, 32'(w_busy), 32'd1);
        tx_valid = 1'b0;
        tx_data = c_W'($urandom);
        cpol = 1'($urandom);
        cpha = 1'($urandom);
        prev_sclk = w_sclk;
        prev_mosi = w_mosi;
        chk({tag, "_setup_sclk"}, 32'(w_sclk), 32'(pol));
        cycles = 0; toggles = 0; leads = 0; nsamp = 0;
        timing_ok = 1'b1; seq_ok = 1'b1; done = 1'b0;
        while (!done && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
            if (w_sclk !== prev_sclk) begin
                toggles++;
                if (cycles != c_DIV * toggles) timing_ok = 1'b0;
                is_lead = toggles[0];
                if (is_lead) leads++;
                if (is_lead ^ pha) begin
                    if (nsamp >= c_W || prev_mosi !== order_bit(tx, nsamp, msb)) seq_ok = 1'b0;
                    nsamp++;
                    if (!lb && nsamp < c_W) miso_drv = order_bit(mword, nsamp, msb);
                end
            end
            if (w_rxv === 1'b1) done = 1'b1;
            prev_sclk = w_sclk;
            prev_mosi = w_mosi;
        end
        chk({tag, "_latency"}, 32'(cycles), 32'(c_LEN));
        chk({tag, "_leads"},   32'(leads),  32'(c_W));
        chk({tag, "_toggles"}, 32'(toggles), 32'(2 * c_W));
        chk({tag, "_timing"},  32'(timing_ok), 32'd1);
        chk({tag, "_mosi_seq"}, 32'(seq_ok), 32'd1);
        chk({tag, "_samples"}, 32'(nsamp), 32'(c_W));
        chk_idle(tag, lb ? tx : mword, pol);
        @(posedge clk); #1;
        chk({tag, "_rxv_pulse"}, 32'(w_rxv), 32'd0);
    endtask

    initial begin
        int cnt;
        int pulses;
        logic [c_W-1:0] t, m;
        logic r_msb, r_pol, r_pha, r_lb;

        // Reset state, held across clock edges
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset", '0, 1'b0);
        chk("reset_rxv", 32'(w_rxv), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_frame("mode0_a5", 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 8'h00);

        // Reset pulse while idle clears the held RX word
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_idle("idle_clr", '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_frame("mode3_3c", 1'b0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h00);
        run_frame("mode1_ff", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF);
        run_frame("mode1_80", 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h80);

        // Back-to-back with TX_VALID held; second word presented mid-frame
        sel = 1'b0; loop = 1'b1;
        @(negedge clk);
        tx_data = 8'h12; cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_data = 8'h34;
        cnt = 0;
        while (w_rxv !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("b2b_first_lat", 32'(cnt), 32'(c_LEN));
        chk("b2b_first_rx",  32'(w_rx), 32'h12);
        chk("b2b_gap_csn",   32'(w_csn), 32'd1);
        @(posedge clk); #1;
        chk("b2b_reaccept_csn", 32'(w_csn), 32'd0);
        tx_valid = 1'b0;
        cnt = 1;
        while (w_rxv !== 1'b1 && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("b2b_period",    32'(cnt), 32'(c_LEN + 1));
        chk("b2b_second_rx", 32'(w_rx), 32'h34);

        // Reset ten cycles into a frame aborts it
        @(negedge clk);
        tx_data = 8'hC3; cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("abort_pre_busy", 32'(w_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_idle("abort", '0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (2 * c_LEN) begin
            @(posedge clk); #1;
            if (w_rxv === 1'b1) pulses++;
        end
        chk("abort_no_rxv", 32'(pulses), 32'd0);
        run_frame("after_abort_5a", 1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 8'h00);

        // Randomized frames: loopback or independent MISO words, any mode/order
        for (int i = 0; i < 12; i++) begin
            t = c_W'($urandom);
            m = c_W'($urandom);
            r_msb = 1'($urandom);
            r_pol = 1'($urandom);
            r_pha = 1'($urandom);
            r_lb  = 1'($urandom);
            run_frame($sformatf("rnd%0d", i), r_msb, t, r_pol, r_pha, r_lb, m);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
